// File: rtl/reg_file.sv
// Integer register file x0..x31: two combinational read ports, one synchronous write port.
// Latency: reads 0 cycles, writes visible the cycle after the edge; no backpressure.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_fire;

  // Entry 0 is reset to zero and never written, so x0 stays hardwired.
  assign wr_fire = wr_en && (rd_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= '{default: '0};
      regs[2] <= DATA_W'(SP_INIT);
    end else if (wr_fire) begin
      regs[rd_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rd_en && (rs1_addr != '0)) begin
      rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && !rst && (rs1_addr == rd_addr)) rs1_data = wr_data;
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rd_en && (rs2_addr != '0)) begin
      rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && !rst && (rs2_addr == rd_addr)) rs2_data = wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench for reg_file against an array-based register model.
module tb_reg_file;

  localparam logic [31:0] SP = 32'h0001_FFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  reg_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(SP)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .wr_data  (wr_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  // Architectural view of a read: what the core should see on a port this cycle.
  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    if (!rd_en || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !rst && rd_addr != 5'd0 && a == rd_addr) return wr_data;
`endif
    return model[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checks = checks + 2;
      if (rs1_data !== expect_rd(rs1_addr)) begin
        errors = errors + 1;
        $display("FAIL model_rs1 t=%0t addr=%0d got=%h want=%h", $time, rs1_addr, rs1_data, expect_rd(rs1_addr));
      end
      if (rs2_data !== expect_rd(rs2_addr)) begin
        errors = errors + 1;
        $display("FAIL model_rs2 t=%0t addr=%0d got=%h want=%h", $time, rs2_addr, rs2_data, expect_rd(rs2_addr));
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic re, input logic [4:0] rda,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; wr_en = we; rd_en = re; rd_addr = rda; wr_data = wd; rs1_addr = a1; rs2_addr = a2;
  endtask

  // Advance one edge and apply the architectural update to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[2] = SP;
    end else if (wr_en && rd_addr != 5'd0) begin
      model[rd_addr] = wr_data;
    end
    #1;
  endtask

  task automatic step(input logic r, input logic we, input logic re, input logic [4:0] rda,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    drive(r, we, re, rda, wd, a1, a2);
    tick();
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  a, b, d;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset with a concurrent write that must be dropped.
    step(1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd2);
    chk_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #2;
      lit("rst_rs1", rs1_data, (i == 2) ? SP : 32'h0);
      lit("rst_rs2", rs2_data, (31 - i == 2) ? SP : 32'h0);
      tick();
    end

    step(1'b0, 1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'd7, 5'd7);
    #2; lit("x7_rs1", rs1_data, 32'h1234_5678); lit("x7_rs2", rs2_data, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #2; lit("rden0_rs1", rs1_data, 32'h0); lit("rden0_rs2", rs2_data, 32'h0);
    tick();

    step(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'd0, 5'd0);
    #2; lit("x0_write", rs1_data, 32'h0);
    tick();

    step(1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0011, 5'd0, 5'd0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 5'd9, 32'hAAAA_AAAA, 5'd9, 5'd9);
    drive(1'b0, 1'b0, 1'b1, 5'd9, 32'hAAAA_AAAA, 5'd9, 5'd0);
    #2; lit("x9_hold", rs1_data, 32'h0000_0011);
    tick();

    step(1'b0, 1'b1, 1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h2, 5'd3, 5'd0);
`ifdef REGFILE_BYPASS_EN
    #2; lit("rdw_x3", rs1_data, 32'h2);
`else
    #2; lit("rdw_x3", rs1_data, 32'h1);
`endif
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'd3, 5'd0);
    #2; lit("x3_after", rs1_data, 32'h2);
    tick();

    // Reset-cycle bypass suppression: output reflects stored contents only.
    drive(1'b1, 1'b1, 1'b1, 5'd3, 32'h5555_5555, 5'd3, 5'd2);
    #2; lit("rst_nobyp", rs1_data, 32'h2);
    tick();

    for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #2;
      lit("fill_rs1", rs1_data, 32'(i) * 32'h0101_0101);
      lit("fill_rs2", rs2_data, 32'(31 - i) * 32'h0101_0101);
      tick();
    end

    for (int n = 0; n < 3000; n++) begin
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      v = $urandom;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) != 0), d, v, a, b);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
